// File: rtl/pulpemu_rst_pkg.sv
// Shared types for the pulpemu reset sequencer: FSM states, reset-cause codes
// and the delay-counter width helper.
package pulpemu_rst_pkg;

    typedef enum logic [2:0] {
        HOLD,
        LOCK_WAIT,
        SOC_DLY,
        CLU_DLY,
        RUN
    } rst_state_e;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'b00,
        CAUSE_EXT  = 2'b01,
        CAUSE_LOCK = 2'b10
    } rst_cause_e;

    // Width able to hold max(a,b)-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/pulpemu_rst_debounce.sv
// Synchronizer plus debouncer for the FMC reset button. q_o follows the
// synchronized input only after DEBOUNCE_CYCLES-1 consecutive disagreeing cycles.
module pulpemu_rst_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   db_reg;
    logic                   db_next;

    // Button side idles released, so everything resets to 1.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_reg <= '1;
            cnt_reg  <= '0;
            db_reg   <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], d_i};
            cnt_reg  <= cnt_next;
            db_reg   <= db_next;
        end
    end

    // Toggle on the edge the count would reach DEBOUNCE_CYCLES-1, clearing it.
    always_comb begin
        cnt_next = '0;
        db_next  = db_reg;
        if (sync_reg[SYNC_STAGES-1] != db_reg) begin
            if (cnt_reg == CNT_LAST) begin
                db_next = ~db_reg;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    assign q_o = db_reg;

endmodule

// File: rtl/pulpemu_rst_seq.sv
// Staged reset sequencer: SoC reset released first, cluster reset later.
// Define PULPEMU_RST_LOCK_LOSS_EN to also abort the sequence on clock-wizard lock loss.
module pulpemu_rst_seq
    import pulpemu_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned SOC_DELAY       = 16,
    parameter int unsigned CLUSTER_DELAY   = 16
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       ext_rstn_i,
    input  logic       clk_locked_i,
    output logic       soc_rstn_o,
    output logic       cluster_rstn_o,
    output logic       busy_o,
    output logic [1:0] rst_cause_o
);

    localparam int unsigned CNT_W = cnt_width(SOC_DELAY, CLUSTER_DELAY);
    localparam logic [CNT_W-1:0] SOC_LOAD = CNT_W'(SOC_DELAY - 1);
    localparam logic [CNT_W-1:0] CLU_LOAD = CNT_W'(CLUSTER_DELAY - 1);

    logic [SYNC_STAGES-1:0] lock_sync_reg;
    logic                   lock_sync;
    logic                   ext_db;
    logic                   ext_db_q_reg;
    logic                   ext_fall;
    logic                   ext_abort;
    logic                   lock_abort;

    rst_state_e       state_reg, state_next;
    rst_cause_e       cause_reg, cause_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             soc_reg, soc_next;
    logic             clu_reg, clu_next;
    logic             busy_reg, busy_next;

    pulpemu_rst_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ext_debounce (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .d_i   (ext_rstn_i),
        .q_o   (ext_db)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lock_sync_reg <= '0;
            ext_db_q_reg  <= 1'b1;
            state_reg     <= HOLD;
            cause_reg     <= CAUSE_POR;
            cnt_reg       <= '0;
            soc_reg       <= 1'b0;
            clu_reg       <= 1'b0;
            busy_reg      <= 1'b1;
        end else begin
            lock_sync_reg <= {lock_sync_reg[SYNC_STAGES-2:0], clk_locked_i};
            ext_db_q_reg  <= ext_db;
            state_reg     <= state_next;
            cause_reg     <= cause_next;
            cnt_reg       <= cnt_next;
            soc_reg       <= soc_next;
            clu_reg       <= clu_next;
            busy_reg      <= busy_next;
        end
    end

    assign lock_sync = lock_sync_reg[SYNC_STAGES-1];
    assign ext_fall  = ext_db_q_reg & ~ext_db;
    assign ext_abort = (state_reg != HOLD) && ext_fall;

`ifdef PULPEMU_RST_LOCK_LOSS_EN
    // These states are only entered with lock high, so a low level is a fall.
    assign lock_abort = ((state_reg == SOC_DLY) || (state_reg == CLU_DLY) ||
                         (state_reg == RUN)) && !lock_sync;
`else
    assign lock_abort = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        cnt_next   = cnt_reg;
        soc_next   = soc_reg;
        clu_next   = clu_reg;
        busy_next  = busy_reg;

        if (ext_abort || lock_abort) begin
            // Button wins when both abort sources fire together.
            state_next = HOLD;
            cause_next = ext_abort ? CAUSE_EXT : CAUSE_LOCK;
            cnt_next   = '0;
            soc_next   = 1'b0;
            clu_next   = 1'b0;
            busy_next  = 1'b1;
        end else begin
            case (state_reg)
                HOLD: begin
                    soc_next   = 1'b0;
                    clu_next   = 1'b0;
                    busy_next  = 1'b1;
                    state_next = LOCK_WAIT;
                end
                LOCK_WAIT: begin
                    if (lock_sync && ext_db) begin
                        state_next = SOC_DLY;
                        cnt_next   = SOC_LOAD;
                    end
                end
                SOC_DLY: begin
                    if (cnt_reg == '0) begin
                        state_next = CLU_DLY;
                        cnt_next   = CLU_LOAD;
                        soc_next   = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                CLU_DLY: begin
                    if (cnt_reg == '0) begin
                        state_next = RUN;
                        clu_next   = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                RUN: begin
                    state_next = RUN;
                end
                default: begin
                    state_next = HOLD;
                end
            endcase
        end
    end

    assign soc_rstn_o     = soc_reg;
    assign cluster_rstn_o = clu_reg;
    assign busy_o         = busy_reg;
    assign rst_cause_o    = cause_reg;

endmodule
